// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract unit: a DIGIT-bit ripple slice walks WIDTH-bit operands
// LSB digit first, one digit per clock, behind a start/done handshake.
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             C_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] S_out,
    output logic             C_out,
    output logic             V_out
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic               busy_d, done_d;
    logic [WIDTH-1:0]   s_d;
    logic               c_d, v_d;

    logic [DIGIT-1:0]   sum_digit;
    logic               ripple;
    logic               carry_msb_in;
    logic               carry_digit;
    logic [WIDTH-1:0]   acc_shift;
    logic               last_digit;

    // Digit slice: ripple through DIGIT full adders; keep the carry into the top bit for V.
    always_comb begin
        ripple       = carry_q;
        carry_msb_in = carry_q;
        sum_digit    = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                carry_msb_in = ripple;
            end
            sum_digit[i] = a_q[i] ^ b_q[i] ^ ripple;
            ripple       = (a_q[i] & b_q[i]) | (ripple & (a_q[i] ^ b_q[i]));
        end
        carry_digit = ripple;
    end

    // New sum digit enters at the top; after N digits the accumulator holds the result.
    assign acc_shift  = (acc_q >> DIGIT) | (WIDTH'(sum_digit) << (WIDTH - DIGIT));
    assign last_digit = (cnt_q == CNT_W'(N - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        busy_d  = busy_out;
        done_d  = 1'b0;
        s_d     = S_out;
        c_d     = C_out;
        v_d     = V_out;

        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    a_d     = A_in;
                    b_d     = sub_in ? ~B_in : B_in;
                    carry_d = sub_in ? ~C_in : C_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = carry_digit;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    s_d     = acc_shift;
                    c_d     = carry_digit;
                    v_d     = carry_msb_in ^ carry_digit;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including results.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
            S_out    <= '0;
            C_out    <= 1'b0;
            V_out    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            busy_out <= busy_d;
            done_out <= done_d;
            S_out    <= s_d;
            C_out    <= c_d;
            V_out    <= v_d;
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: DIGIT=1 and DIGIT=4 instances against an arithmetic reference model.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start4;
    logic       sub;
    logic [7:0] a, b;
    logic       ci;

    logic       busy1, done1, c1, v1;
    logic [7:0] s1;
    logic       busy4, done4, c4, v4;
    logic [7:0] s4;

    int errors = 0;
    int checks = 0;

    logic [7:0] prev_s [2];
    logic       prev_c [2];
    logic       prev_v [2];

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .sub_in(sub),
        .A_in(a), .B_in(b), .C_in(ci),
        .busy_out(busy1), .done_out(done1), .S_out(s1), .C_out(c1), .V_out(v1)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start4), .sub_in(sub),
        .A_in(a), .B_in(b), .C_in(ci),
        .busy_out(busy4), .done_out(done4), .S_out(s4), .C_out(c4), .V_out(v4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; returns {V, C, S}.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic cin, input logic sb);
        int         r;
        logic [7:0] s;
        logic       c, v;
        if (!sb) begin
            r = int'(x) + int'(y) + int'(cin);
            c = (r > 255);
        end else begin
            r = int'(x) - int'(y) - int'(cin);
            c = (r >= 0);
        end
        s = 8'(r);
        v = sb ? ((x[7] != y[7]) && (s[7] != x[7])) : ((x[7] == y[7]) && (s[7] != x[7]));
        return {v, c, s};
    endfunction

    task automatic sample(input int sel, output logic bsy, output logic dn,
                          output logic [7:0] s, output logic c, output logic v);
        if (sel == 0) begin
            bsy = busy1; dn = done1; s = s1; c = c1; v = v1;
        end else begin
            bsy = busy4; dn = done4; s = s4; c = c4; v = v4;
        end
    endtask

    task automatic set_start(input int sel, input logic val);
        if (sel == 0) start1 = val;
        else          start4 = val;
    endtask

    task automatic randomize_inputs();
        a   = 8'($urandom);
        b   = 8'($urandom);
        ci  = 1'($urandom);
        sub = 1'($urandom);
    endtask

    // One operation; interfere>0 re-pulses start with new operands before that RUN edge.
    task automatic run_op(input int sel, input logic [7:0] oa, input logic [7:0] ob,
                          input logic oci, input logic osub, input int interfere);
        int         n;
        int         lat;
        logic [9:0] exp;
        logic       bsy, dn, c, v;
        logic [7:0] s;
        n   = (sel == 0) ? 8 : 2;
        lat = 0;
        exp = model(oa, ob, oci, osub);
        a = oa; b = ob; ci = oci; sub = osub;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        randomize_inputs();
        sample(sel, bsy, dn, s, c, v);
        check("busy_after_start", 32'(bsy), 32'd1);
        check("done_after_start", 32'(dn), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            if (k == interfere) begin
                randomize_inputs();
                set_start(sel, 1'b1);
            end
            @(posedge clk); #1;
            set_start(sel, 1'b0);
            sample(sel, bsy, dn, s, c, v);
            if (dn) begin
                lat = k;
                break;
            end
            check("busy_in_run", 32'(bsy), 32'd1);
            check("s_held_in_run", 32'(s), 32'(prev_s[sel]));
            check("cv_held_in_run", 32'({c, v}), 32'({prev_c[sel], prev_v[sel]}));
        end
        check("latency", 32'(lat), 32'(n));
        check("busy_at_done", 32'(bsy), 32'd0);
        check("s_result", 32'(s), 32'(exp[7:0]));
        check("c_result", 32'(c), 32'(exp[8]));
        check("v_result", 32'(v), 32'(exp[9]));
        prev_s[sel] = exp[7:0];
        prev_c[sel] = exp[8];
        prev_v[sel] = exp[9];
        @(posedge clk); #1;
        sample(sel, bsy, dn, s, c, v);
        check("done_single_pulse", 32'(dn), 32'd0);
        check("busy_after_done", 32'(bsy), 32'd0);
        if (interfere > 0) begin
            for (int k = 0; k < n; k++) begin
                @(posedge clk); #1;
                sample(sel, bsy, dn, s, c, v);
                check("no_queued_op", 32'({bsy, dn}), 32'd0);
                check("s_stable_idle", 32'(s), 32'(prev_s[sel]));
            end
        end
    endtask

    task automatic check_zero(input int sel, input string tag);
        logic       bsy, dn, c, v;
        logic [7:0] s;
        sample(sel, bsy, dn, s, c, v);
        check(tag, 32'({bsy, dn, c, v, s}), 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        rst_n  = 1'b0;
        start1 = 1'b1;
        start4 = 1'b1;
        a = 8'hAA; b = 8'h55; ci = 1'b1; sub = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        start1 = 1'b0;
        start4 = 1'b0;
        check_zero(0, "reset_state_d1");
        check_zero(1, "reset_state_d4");
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            prev_s[i] = '0; prev_c[i] = 1'b0; prev_v[i] = 1'b0;
        end
        @(posedge clk); #1;

        // Directed cases
        run_op(0, 8'd200, 8'd100, 1'b0, 1'b0, 0);
        run_op(0, 8'd100, 8'd100, 1'b0, 1'b0, 0);
        run_op(0, 8'd5,   8'd7,   1'b0, 1'b1, 0);
        run_op(0, 8'h80,  8'h01,  1'b0, 1'b1, 0);
        run_op(0, 8'h00,  8'h00,  1'b1, 1'b0, 0);
        run_op(0, 8'hFF,  8'hFF,  1'b1, 1'b0, 0);
        run_op(0, 8'h00,  8'h00,  1'b1, 1'b1, 0);
        run_op(0, 8'h7F,  8'h80,  1'b0, 1'b1, 0);
        run_op(1, 8'hFF,  8'h01,  1'b0, 1'b0, 0);
        run_op(1, 8'h7F,  8'h01,  1'b0, 1'b0, 0);
        run_op(1, 8'h80,  8'hFF,  1'b1, 1'b1, 0);

        // Start pulsed mid-RUN must be ignored
        run_op(0, 8'd37, 8'd91, 1'b1, 1'b0, 3);

        // Reset in the middle of RUN aborts the operation
        a = 8'h3C; b = 8'h99; ci = 1'b0; sub = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_zero(0, "abort_reset_d1");
        check_zero(1, "abort_reset_d4");
        for (int i = 0; i < 2; i++) begin
            prev_s[i] = '0; prev_c[i] = 1'b0; prev_v[i] = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("no_done_after_abort", 32'({busy1, done1}), 32'd0);
        end
        run_op(0, 8'h3C, 8'h99, 1'b0, 1'b1, 0);

        // Random operations on both widths
        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(0, ra, rb, 1'($urandom), 1'($urandom), 0);
        end
        for (int i = 0; i < 15; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(1, ra, rb, 1'($urandom), 1'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
